// File: rtl/wb_regfile.sv
// wb_regfile - writeback stage of the pipeline.
//
// Picks the writeback value (load data or ALU result), commits it into a
// 32 x XLEN integer register file on the rising clock edge, and serves the
// two ID-stage read ports. A write presented in the current cycle is
// bypassed straight to the read ports, so ID never sees stale data.
//
// Ports
//   clk           pipeline clock, all state changes on posedge
//   rst           synchronous active-high reset
//   MemtoReg_wb   1: write MemDout_wb, 0: write ALUResult_wb
//   RegWrite_wb   writeback enable
//   MemDout_wb    load data from MEM/WB
//   ALUResult_wb  ALU result from MEM/WB
//   rdAddr_wb     destination register index
//   rs1Addr_id    read port 1 index
//   rs2Addr_id    read port 2 index
//   rs1Data_id    read port 1 data (combinational)
//   rs2Data_id    read port 2 data (combinational)
//   WriteData_wb  selected writeback value (EX forwarding source)
//   wbWrEn        a write actually commits this cycle
//   wbCount       number of committed writes, wraps silently
module wb_regfile #(
  parameter int NREG = 32,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MemtoReg_wb,
  input  logic            RegWrite_wb,
  input  logic [XLEN-1:0] MemDout_wb,
  input  logic [XLEN-1:0] ALUResult_wb,
  input  logic [4:0]      rdAddr_wb,
  input  logic [4:0]      rs1Addr_id,
  input  logic [4:0]      rs2Addr_id,
  output logic [XLEN-1:0] rs1Data_id,
  output logic [XLEN-1:0] rs2Data_id,
  output logic [XLEN-1:0] WriteData_wb,
  output logic            wbWrEn,
  output logic [31:0]     wbCount
);

  // x0 is not stored at all; reads of index 0 are forced to zero below.
  logic [XLEN-1:0] regs [1:NREG-1];

  assign WriteData_wb = MemtoReg_wb ? MemDout_wb : ALUResult_wb;

  // Reset gates the enable so a writeback arriving with rst is neither
  // committed nor bypassed.
  assign wbWrEn = RegWrite_wb & (rdAddr_wb != 5'd0) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREG; i++) begin
        regs[i] <= '0;
      end
      wbCount <= '0;
    end else if (wbWrEn) begin
      regs[rdAddr_wb] <= WriteData_wb;
      wbCount         <= wbCount + 32'd1;
    end
  end

  always_comb begin
    rs1Data_id = '0;
    if (rs1Addr_id == 5'd0) begin
      rs1Data_id = '0;
    end else if (wbWrEn && (rs1Addr_id == rdAddr_wb)) begin
      rs1Data_id = WriteData_wb;
    end else begin
      rs1Data_id = regs[rs1Addr_id];
    end
  end

  always_comb begin
    rs2Data_id = '0;
    if (rs2Addr_id == 5'd0) begin
      rs2Data_id = '0;
    end else if (wbWrEn && (rs2Addr_id == rdAddr_wb)) begin
      rs2Data_id = WriteData_wb;
    end else begin
      rs2Data_id = regs[rs2Addr_id];
    end
  end

endmodule
